// File: rtl/huffman_stream_ctrl.sv
// huffman_stream_ctrl: job sequencer for the serial Huffman front end.
// Fetches compressed words from an upstream valid/ready source, strobes them
// into the parallel-to-serial shifter, tracks how many bits have been shifted,
// forwards and counts decoded symbols, and closes the job once the programmed
// symbol count is reached or the job is aborted.
module huffman_stream_ctrl #(
  parameter int WORD_W = 32,
  parameter int SYM_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  sym_target,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [WORD_W-1:0] pts_data,
  output logic              pts_load,
  input  logic              pts_bit_valid,
  input  logic [SYM_W-1:0]  dec_sym,
  input  logic              dec_sym_valid,
  output logic [SYM_W-1:0]  sym_out,
  output logic              sym_out_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sym_cnt
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [CNT_W-1:0]   target_r, target_s;
  logic [WORD_W-1:0]  pts_data_s;
  logic               pts_load_s;
  logic [SYM_W-1:0]   sym_out_s;
  logic               sym_out_valid_s;
  logic               busy_s;
  logic               done_s;
  logic [CNT_W-1:0]   sym_cnt_s;
  logic               sym_take_s;
  logic               sym_last_s;

  // The only combinational output: the controller is ready exactly while fetching.
  assign word_ready = (state_r == ST_FETCH);

  // Next-state and next-output logic; symbol forwarding is shared by FETCH and SHIFT.
  always_comb begin
    state_s         = state_r;
    bit_cnt_s       = bit_cnt_r;
    target_s        = target_r;
    pts_data_s      = pts_data;
    pts_load_s      = 1'b0;
    sym_out_s       = sym_out;
    sym_out_valid_s = 1'b0;
    busy_s          = busy;
    done_s          = 1'b0;
    sym_cnt_s       = sym_cnt;

    // Symbols only count while a job is actively fetching or shifting.
    sym_take_s = ((state_r == ST_FETCH) || (state_r == ST_SHIFT)) && dec_sym_valid;
    sym_last_s = sym_take_s && ((sym_cnt + CNT_W'(1)) == target_r);

    if (sym_take_s) begin
      sym_out_s       = dec_sym;
      sym_out_valid_s = 1'b1;
      sym_cnt_s       = sym_cnt + CNT_W'(1);
    end else begin
      sym_out_valid_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        // abort outranks a simultaneous start.
        if (start && !abort) begin
          target_s  = sym_target;
          sym_cnt_s = {CNT_W{1'b0}};
          busy_s    = 1'b1;
          if (sym_target == {CNT_W{1'b0}}) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // word_ready is high here, so a valid word is consumed even if the job ends now.
        if (word_valid) begin
          pts_data_s = word_in;
          pts_load_s = 1'b1;
          bit_cnt_s  = {BIT_W{1'b0}};
          state_s    = ST_SHIFT;
        end else begin
          state_s = ST_FETCH;
        end
        if (abort || sym_last_s) begin
          state_s = ST_FIN;
        end else begin
          bit_cnt_s = bit_cnt_s;
        end
      end
      ST_SHIFT: begin
        // Return to FETCH only after the last bit has left the shifter.
        if (pts_bit_valid) begin
          bit_cnt_s = bit_cnt_r + BIT_W'(1);
          if (bit_cnt_r == LAST_BIT) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_SHIFT;
        end
        // Job end outranks word completion; leftover bits are ignored.
        if (abort || sym_last_s) begin
          state_s = ST_FIN;
        end else begin
          bit_cnt_s = bit_cnt_s;
        end
      end
      ST_FIN: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= {BIT_W{1'b0}};
      target_r      <= {CNT_W{1'b0}};
      pts_data      <= {WORD_W{1'b0}};
      pts_load      <= 1'b0;
      sym_out       <= {SYM_W{1'b0}};
      sym_out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      sym_cnt       <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      bit_cnt_r     <= bit_cnt_s;
      target_r      <= target_s;
      pts_data      <= pts_data_s;
      pts_load      <= pts_load_s;
      sym_out       <= sym_out_s;
      sym_out_valid <= sym_out_valid_s;
      busy          <= busy_s;
      done          <= done_s;
      sym_cnt       <= sym_cnt_s;
    end
  end

endmodule
